ram256_fifo_ctrl: RTL and testbench

RAM256_FIFO_CTRL -- requirements
Module: ram256_fifo_ctrl

---
 rtl/ram256_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_ram256_fifo_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram256_fifo_ctrl.sv
// FIFO controller in front of an 8x256 two-port RAM with a 1-cycle read latency.
// A 2-entry skid buffer absorbs the read latency so the head word can stream at one per cycle.
module ram256_fifo_ctrl (
  input  logic         clockCore,
  input  logic         resetCore,
  input  logic         clear,
  input  logic         pushValid,
  input  logic [255:0] pushData,
  output logic         pushReady,
  output logic         popValid,
  output logic [255:0] popData,
  input  logic         popReady,
  output logic [3:0]   level,
  output logic         ramEnableWrite,
  output logic [2:0]   ramAddressWrite,
  output logic [255:0] ramWriteData,
  output logic         ramEnableRead,
  output logic [2:0]   ramAddressRead,
  input  logic [255:0] ramReadData
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on the partner's valid, and a refused offer changes no state.

  logic [2:0]   wr_ptr_q, wr_ptr_d;
  logic [2:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]   ram_count_q, ram_count_d;
  logic         in_flight_q, in_flight_d;
  logic [1:0]   skid_count_q, skid_count_d;
  logic [255:0] skid0_q, skid0_d;
  logic [255:0] skid1_q, skid1_d;
  logic [3:0]   level_q, level_d;

  logic         push_fire;
  logic         pop_fire;
  logic         read_go;
  logic [1:0]   occ;

  assign pushReady       = !resetCore && !clear && (ram_count_q != 4'd8);
  assign popValid        = !resetCore && (skid_count_q != 2'd0);
  assign popData         = skid0_q;
  assign level           = level_q;
  assign ramEnableWrite  = push_fire;
  assign ramAddressWrite = resetCore ? 3'd0 : wr_ptr_q;
  assign ramWriteData    = pushData;
  assign ramEnableRead   = read_go;
  assign ramAddressRead  = resetCore ? 3'd0 : rd_ptr_q;

  always_comb begin
    push_fire = pushValid && pushReady;
    pop_fire  = popValid && popReady;
    // Skid slots already committed: held words plus the one returning from the RAM.
    occ       = skid_count_q + {1'b0, in_flight_q};
    read_go   = !resetCore && !clear && (ram_count_q != 4'd0) &&
                ((occ < 2'd2) || ((occ == 2'd2) && pop_fire));

    wr_ptr_d    = wr_ptr_q + {2'b00, push_fire};
    rd_ptr_d    = rd_ptr_q + {2'b00, read_go};
    ram_count_d = ram_count_q + {3'b000, push_fire} - {3'b000, read_go};
    in_flight_d = read_go;

    skid0_d      = skid0_q;
    skid1_d      = skid1_q;
    skid_count_d = skid_count_q;
    if (pop_fire) begin
      skid0_d      = skid1_q;
      skid_count_d = skid_count_d - 2'd1;
    end
    // The returning word lands behind whatever survives this cycle's pop.
    if (in_flight_q) begin
      if (skid_count_d == 2'd0) skid0_d = ramReadData;
      else                      skid1_d = ramReadData;
      skid_count_d = skid_count_d + 2'd1;
    end

    if (clear) begin
      wr_ptr_d     = 3'd0;
      rd_ptr_d     = 3'd0;
      ram_count_d  = 4'd0;
      in_flight_d  = 1'b0;
      skid_count_d = 2'd0;
    end

    level_d = ram_count_d + {3'b000, in_flight_d} + {2'b00, skid_count_d};
  end

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      wr_ptr_q     <= 3'd0;
      rd_ptr_q     <= 3'd0;
      ram_count_q  <= 4'd0;
      in_flight_q  <= 1'b0;
      skid_count_q <= 2'd0;
      skid0_q      <= '0;
      skid1_q      <= '0;
      level_q      <= 4'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_count_q  <= ram_count_d;
      in_flight_q  <= in_flight_d;
      skid_count_q <= skid_count_d;
      skid0_q      <= skid0_d;
      skid1_q      <= skid1_d;
      level_q      <= level_d;
    end
  end

endmodule

// File: tb/tb_ram256_fifo_ctrl.sv
// Bench for ram256_fifo_ctrl: behavioural 8x256 RAM, expected-word queue filled on accepted
// pushes and drained on pops, plus directed checks for latency, fill, flush and reset.
module tb_ram256_fifo_ctrl;

  logic         clk = 1'b0;
  logic         reset_core;
  logic         clear;
  logic         push_valid;
  logic [255:0] push_data;
  logic         push_ready;
  logic         pop_valid;
  logic [255:0] pop_data;
  logic         pop_ready;
  logic [3:0]   level;
  logic         ram_enable_write;
  logic [2:0]   ram_address_write;
  logic [255:0] ram_write_data;
  logic         ram_enable_read;
  logic [2:0]   ram_address_read;
  logic [255:0] ram_read_data;

  logic [255:0] mem [8];
  logic [255:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           push_cnt = 0;
  int           pop_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [255:0] stall_data = '0;

  ram256_fifo_ctrl dut (
    .clockCore(clk), .resetCore(reset_core), .clear(clear),
    .pushValid(push_valid), .pushData(push_data), .pushReady(push_ready),
    .popValid(pop_valid), .popData(pop_data), .popReady(pop_ready),
    .level(level),
    .ramEnableWrite(ram_enable_write), .ramAddressWrite(ram_address_write),
    .ramWriteData(ram_write_data),
    .ramEnableRead(ram_enable_read), .ramAddressRead(ram_address_read),
    .ramReadData(ram_read_data)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_enable_write) mem[ram_address_write] <= ram_write_data;
    if (ram_enable_read)  ram_read_data <= mem[ram_address_read];
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // scoreboard: observe mid-cycle, ahead of the edge that completes each transfer
  always @(negedge clk) begin : mon
    logic [255:0] e;
    if (reset_core) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("level", {252'd0, level}, exp_q.size());
      if (stall_prev && pop_valid) check("stall_hold", pop_data, stall_data);
      if (push_valid && push_ready) begin
        exp_q.push_back(push_data);
        push_cnt++;
      end
      if (pop_valid && pop_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("pop_underflow", {255'd0, pop_valid}, 256'd0);
        else begin
          e = exp_q.pop_front();
          check("pop_data", pop_data, e);
        end
      end
      stall_prev = pop_valid && !pop_ready;
      stall_data = pop_data;
      if (clear) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input bit pr);
    int base;
    pop_ready = pr;
    for (int i = 0; i < n; i++) begin
      push_valid = 1'b1;
      push_data  = rand256();
      base       = push_cnt;
      for (int t = 0; t < 50 && push_cnt == base; t++) step();
      if (push_cnt == base) check("push_timeout", push_cnt - base, 256'd1);
    end
    push_valid = 1'b0;
  endtask

  task automatic drain();
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
    check("drain_timeout", exp_q.size(), 256'd0);
    pop_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic reset_checks();
    @(negedge clk);
    check("rst_push_ready", {255'd0, push_ready}, 256'd0);
    check("rst_ram_we", {255'd0, ram_enable_write}, 256'd0);
    check("rst_ram_re", {255'd0, ram_enable_read}, 256'd0);
    check("rst_ram_wa", {253'd0, ram_address_write}, 256'd0);
    check("rst_ram_ra", {253'd0, ram_address_read}, 256'd0);
    check("rst_pop_valid", {255'd0, pop_valid}, 256'd0);
    check("rst_level", {252'd0, level}, 256'd0);
    check("rst_pop_data", pop_data, 256'd0);
  endtask

  task automatic expect_first_pop(input string tag, input logic [255:0] word);
    for (int t = 0; t < 20 && !pop_valid; t++) @(negedge clk);
    check({tag, "_valid"}, {255'd0, pop_valid}, 256'd1);
    check({tag, "_data"}, pop_data, word);
  endtask

  initial begin
    logic [255:0] w;
    int base, pbase, last;
    reset_core = 1'b1; clear = 1'b0; push_valid = 1'b1; push_data = '1; pop_ready = 1'b1;
    repeat (3) step();
    reset_checks();
    step();
    reset_core = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {255'd0, push_ready}, 256'd1);

    // single word latency
    step();
    w = {32{8'hA5}};
    push_valid = 1'b1; push_data = w; pop_ready = 1'b1;
    @(negedge clk);
    step();
    push_valid = 1'b0;
    @(negedge clk);
    check("lat_read_issue", {255'd0, ram_enable_read}, 256'd1);
    check("lat_read_addr", {253'd0, ram_address_read}, 256'd0);
    @(negedge clk);
    check("lat_c2_not_valid", {255'd0, pop_valid}, 256'd0);
    @(negedge clk);
    check("lat_c3_valid", {255'd0, pop_valid}, 256'd1);
    check("lat_c3_data", pop_data, w);
    @(negedge clk);
    check("lat_c4_level", {252'd0, level}, 256'd0);
    drain();

    // fill with the output stalled
    base = push_cnt;
    pop_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_valid = 1'b1;
      push_data  = rand256();
      @(negedge clk);
      if (i >= 4)  check("fill_no_read", {255'd0, ram_enable_read}, 256'd0);
      if (i >= 10) check("fill_ready_low", {255'd0, push_ready}, 256'd0);
      step();
    end
    push_valid = 1'b0;
    @(negedge clk);
    check("fill_accepted", push_cnt - base, 256'd10);
    check("fill_level", {252'd0, level}, 256'd10);
    check("fill_ready", {255'd0, push_ready}, 256'd0);
    check("fill_re", {255'd0, ram_enable_read}, 256'd0);
    drain();

    // streaming, incrementing data
    base = push_cnt; pbase = pop_cnt;
    push_valid = 1'b1; pop_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_data = 256'(i + 32'h100);
      step();
    end
    push_valid = 1'b0;
    check("stream_pushes", push_cnt - base, 256'd40);
    check("stream_pops", pop_cnt - pbase, 256'd37);
    drain();

    // full RAM, one pop, ready returns a cycle later, next write wraps to slot 0
    do_clear();
    push_words(6, 1'b1);
    drain();
    push_words(10, 1'b0);
    @(negedge clk);
    check("full_level", {252'd0, level}, 256'd10);
    check("full_ready", {255'd0, push_ready}, 256'd0);
    step();
    pop_ready = 1'b1;
    @(negedge clk);
    check("full_ready_same_cycle", {255'd0, push_ready}, 256'd0);
    step();
    pop_ready = 1'b0;
    @(negedge clk);
    check("full_ready_next_cycle", {255'd0, push_ready}, 256'd1);
    step();
    push_valid = 1'b1; push_data = rand256();
    @(negedge clk);
    check("full_wrap_we", {255'd0, ram_enable_write}, 256'd1);
    check("full_wrap_addr", {253'd0, ram_address_write}, 256'd0);
    step();
    drain();

    // random backpressure
    base = push_cnt; last = push_cnt; w = rand256();
    for (int cyc = 0; cyc < 3000 && push_cnt - base < 200; cyc++) begin
      if (push_cnt != last) begin
        w = rand256();
        last = push_cnt;
      end
      push_valid = ($urandom_range(0, 3) != 0);
      push_data  = w;
      pop_ready  = $urandom_range(0, 1);
      step();
    end
    push_valid = 1'b0;
    check("bp_accepted", push_cnt - base, 256'd200);
    drain();

    // flush with a read in flight
    push_words(7, 1'b0);
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0; clear = 1'b1; push_valid = 1'b1; push_data = rand256();
    @(negedge clk);
    check("clr_level_before", {252'd0, level}, 256'd6);
    check("clr_ready", {255'd0, push_ready}, 256'd0);
    check("clr_we", {255'd0, ram_enable_write}, 256'd0);
    check("clr_re", {255'd0, ram_enable_read}, 256'd0);
    step();
    clear = 1'b0; push_valid = 1'b0;
    @(negedge clk);
    check("clr_level_after", {252'd0, level}, 256'd0);
    check("clr_pop_valid", {255'd0, pop_valid}, 256'd0);
    step();
    push_words(1, 1'b1);
    expect_first_pop("clr_first", exp_q.size() != 0 ? exp_q[0] : 256'd0);
    drain();

    // reset mid-transfer
    push_words(3, 1'b0);
    reset_core = 1'b1; push_valid = 1'b1; push_data = rand256();
    step();
    reset_checks();
    step();
    reset_core = 1'b0; push_valid = 1'b0;
    @(negedge clk);
    check("rst2_ready", {255'd0, push_ready}, 256'd1);
    check("rst2_pop_data", pop_data, 256'd0);
    check("rst2_pop_valid", {255'd0, pop_valid}, 256'd0);
    step();
    w = rand256();
    pop_ready = 1'b1; push_valid = 1'b1; push_data = w;
    step();
    push_valid = 1'b0;
    expect_first_pop("rst2_first", w);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
